mcp9808_scheduler: RTL
======================

// Module: mcp9808_scheduler
// PURPOSE
//  Command sequencer in front of the mcp9808 interface block. Arbitrates host requests
//  (shutdown, T-boundary writes, resolution change, periodic/on-demand samples), issues one
//  sensor op at a time with correct level/pulse timing, waits for completion via sns_ready,
//  and returns samples. Sits between host/GPIO logic and mcp9808.
// PARAMETERS
//  PERIOD_CYCLES   1000000  clk cycles between automatic samples (>=2)
//  TIMEOUT_CYCLES  65535    max clk cycles in any wait state before err_timeout
//  CNT_W           24       width of period/timeout counters; must hold both values
//  RES_DEFAULT     2'b11    sns_res value after reset (matches sensor power-on value)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset, synchronous, active-high
//  sample_en      in   1   enable periodic sampling
//  sample_now     in   1   pulse: request one sample
//  host_shutdown  in   1   level: 1 = sensor in shutdown
//  res_req        in   2   requested resolution (level)
//  bnd_req_valid  in   1   pulse: boundary write request
//  bnd_req_kind   in   2   11=T_CRIT 10=T_UPPR 01=T_LOWR 00=ignored
//  bnd_req_val    in   11  boundary value, same format as sensor tempInput
//  err_clr        in   1   clears err_timeout
//  sample_valid   out  1   one-cycle pulse, sample_data valid
//  sample_data    out  16  {comp[2:0],sign,val[11:0]} captured from sensor
//  busy           out  1   op in flight (state != IDLE/SHDN)
//  in_shutdown    out  1   state == SHDN
//  err_timeout    out  1   sticky: a wait state expired
//  sns_ready      in   1   mcp9808 ready
//  sns_temp       in   16  mcp9808 {tempComp,tempSign,tempVal}
//  sns_update / sns_tempWrite[2] / sns_tempInput[11] / sns_res[2] / sns_shutdown  out -> mcp9808
// BEHAVIOUR
//  Reset: all outputs 0 except sns_res=RES_DEFAULT; slots/pending cleared; timer=0; state IDLE.
//  Reset mid-op aborts immediately; mcp9808 is reset on the same rst.
//  States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SHDN.
//  Pending sources: 3 boundary slots (one per kind, new request of same kind overwrites value,
//   kind 00 dropped), res_pend = (res_req != sns_res), smp_pend (set by sample_now or timer expiry,
//   saturates at 1, cleared when sample op issued).
//  Timer: counts while sample_en & state!=SHDN; at PERIOD_CYCLES-1 wraps to 0 and sets smp_pend.
//  IDLE, sns_ready=1, priority: host_shutdown > T_CRIT > T_UPPR > T_LOWR > res > sample.
//   shutdown: sns_shutdown<=1 -> WAIT_BUSY (op=SHDN_ENTER).
//   boundary: sns_tempInput<=slot value, sns_tempWrite<=kind for exactly one cycle (ISSUE), slot cleared.
//   res: sns_res<=res_req (level, held until next res op).
//   sample: sns_update=1 for exactly one cycle (ISSUE).
//  IDLE with sns_ready=0: wait, no issue.
//  ISSUE (1 cycle) -> WAIT_BUSY. sns_tempInput/sns_res/sns_shutdown held stable until op done.
//  WAIT_BUSY: sns_ready=0 -> WAIT_DONE. WAIT_DONE: sns_ready=1 -> done.
//  Done: sample op -> sample_data<=sns_temp, sample_valid=1 next cycle; SHDN_ENTER -> SHDN;
//   SHDN_EXIT and others -> IDLE.
//  SHDN: host_shutdown=0 -> sns_shutdown<=0, op=SHDN_EXIT, WAIT_BUSY. Other requests stay pending.
//  Timeout: counter cleared on entry to WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES sets
//   err_timeout, drops outputs to idle levels (sns_shutdown keeps host_shutdown), -> IDLE.
//   No sample_valid on timed-out op. err_clr clears; err set wins if same cycle.
//  Simultaneous bnd_req_valid with slot issue of same kind: new value kept pending.
// STRUCTURE
//  mcp9808_pkg: tempWrite kind codes (NO_T/T_LOWR/T_UPPR/T_CRIT), scheduler state and op encodings.
//  Sub-module mcp9808_sched_timer: period counter + smp_pend generation; rest in one always block.
// TESTING (bench models mcp9808 ready: drops 1 cycle after command, returns N cycles later)
//  sample_now, sensor returns 16'h0190 after 50 cyc -> one sns_update pulse, sample_valid with 16'h0190.
//  bnd_req T_LOWR val 11'h0A0 then T_CRIT 11'h550 same cycle-pair -> T_CRIT issued first, then T_LOWR; tempWrite 1 cycle each, tempInput stable.
//  res_req 2'b11->2'b01 with sample pending -> res op first (sns_res=01), then sample.
//  host_shutdown=1 during sample op -> sample completes, then shutdown; in_shutdown=1; release -> IDLE.
//  Model never drops ready -> err_timeout after TIMEOUT_CYCLES, state IDLE; err_clr clears.
//  PERIOD_CYCLES=100, sample_en=1 for 1000 cyc, no stalls -> exactly 10 samples; rst mid-wait -> all outputs reset values.

Source files
------------

// File: rtl/mcp9808_pkg.sv
// Shared encodings for the mcp9808 command scheduler: tempWrite kinds,
// scheduler states and the kind of op currently in flight.
package mcp9808_pkg;

  localparam logic [1:0] NO_T   = 2'b00;
  localparam logic [1:0] T_LOWR = 2'b01;
  localparam logic [1:0] T_UPPR = 2'b10;
  localparam logic [1:0] T_CRIT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_SHDN
  } sched_state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_BND,
    OP_RES,
    OP_SAMPLE,
    OP_SHDN_ENTER,
    OP_SHDN_EXIT
  } sched_op_t;

endpackage

// File: rtl/mcp9808_sched_timer.sv
// Periodic sample timer: wraps every PERIOD_CYCLES enabled cycles and keeps a
// saturating sample-pending flag that also absorbs on-demand requests.
module mcp9808_sched_timer #(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en,
  input  logic sample_now,
  input  logic pend_clr,
  output logic smp_pend
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = cnt_en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      smp_pend <= 1'b0;
    end else begin
      if (cnt_en) cnt <= expire ? '0 : cnt + 1'b1;
      // a new request in the same cycle as the issue stays pending
      if (sample_now || expire) smp_pend <= 1'b1;
      else if (pend_clr)        smp_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/mcp9808_scheduler.sv
// Command sequencer in front of the mcp9808 block: arbitrates host requests and
// runs one sensor op at a time, handshaking on sns_ready.
//
//  state        | meaning
//  ST_IDLE      | nothing in flight, pick next request when sensor ready
//  ST_ISSUE     | one-cycle strobe (sns_update / sns_tempWrite) is on the bus
//  ST_WAIT_BUSY | waiting for sensor to drop ready
//  ST_WAIT_DONE | waiting for sensor to raise ready again
//  ST_SHDN      | sensor held in shutdown until host releases it
module mcp9808_scheduler
  import mcp9808_pkg::*;
#(
  parameter int         PERIOD_CYCLES  = 1000000,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         CNT_W          = 24,
  parameter logic [1:0] RES_DEFAULT    = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        sample_now,
  input  logic        host_shutdown,
  input  logic [1:0]  res_req,
  input  logic        bnd_req_valid,
  input  logic [1:0]  bnd_req_kind,
  input  logic [10:0] bnd_req_val,
  input  logic        err_clr,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic        busy,
  output logic        in_shutdown,
  output logic        err_timeout,
  input  logic        sns_ready,
  input  logic [15:0] sns_temp,
  output logic        sns_update,
  output logic [1:0]  sns_tempWrite,
  output logic [10:0] sns_tempInput,
  output logic [1:0]  sns_res,
  output logic        sns_shutdown
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t     state;
  sched_op_t        op;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:1]       slot_vld;
  logic [10:0]      slot_val [3:1];
  logic [1:0]       pick_kind;
  logic             res_pend;
  logic             smp_pend;
  logic             issue_smp;
  logic             tmo_hit;

  assign busy        = (state != ST_IDLE) && (state != ST_SHDN);
  assign in_shutdown = (state == ST_SHDN);
  assign res_pend    = (res_req != sns_res);
  assign tmo_hit     = (tmo_cnt >= TMO_LAST);

  always_comb begin
    pick_kind = NO_T;
    if      (slot_vld[3]) pick_kind = T_CRIT;
    else if (slot_vld[2]) pick_kind = T_UPPR;
    else if (slot_vld[1]) pick_kind = T_LOWR;
  end

  assign issue_smp = (state == ST_IDLE) && sns_ready && !host_shutdown &&
                     (pick_kind == NO_T) && !res_pend && smp_pend;

  mcp9808_sched_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .cnt_en    (sample_en && (state != ST_SHDN)),
    .sample_now(sample_now),
    .pend_clr  (issue_smp),
    .smp_pend  (smp_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      op            <= OP_NONE;
      tmo_cnt       <= '0;
      slot_vld      <= '0;
      for (int k = 1; k <= 3; k++) slot_val[k] <= '0;
      sample_valid  <= 1'b0;
      sample_data   <= '0;
      err_timeout   <= 1'b0;
      sns_update    <= 1'b0;
      sns_tempWrite <= NO_T;
      sns_tempInput <= '0;
      sns_res       <= RES_DEFAULT;
      sns_shutdown  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (sns_ready) begin
            if (host_shutdown) begin
              sns_shutdown <= 1'b1;
              op           <= OP_SHDN_ENTER;
              state        <= ST_WAIT_BUSY;
            end else if (pick_kind != NO_T) begin
              sns_tempInput       <= slot_val[pick_kind];
              sns_tempWrite       <= pick_kind;
              slot_vld[pick_kind] <= 1'b0;
              op                  <= OP_BND;
              state               <= ST_ISSUE;
            end else if (res_pend) begin
              sns_res <= res_req;
              op      <= OP_RES;
              state   <= ST_ISSUE;
            end else if (smp_pend) begin
              sns_update <= 1'b1;
              op         <= OP_SAMPLE;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          sns_update    <= 1'b0;
          sns_tempWrite <= NO_T;
          tmo_cnt       <= '0;
          state         <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if ((state == ST_WAIT_BUSY) && !sns_ready) begin
            tmo_cnt <= '0;
            state   <= ST_WAIT_DONE;
          end else if ((state == ST_WAIT_DONE) && sns_ready) begin
            if (op == OP_SAMPLE) begin
              sample_data  <= sns_temp;
              sample_valid <= 1'b1;
            end
            state <= (op == OP_SHDN_ENTER) ? ST_SHDN : ST_IDLE;
            op    <= OP_NONE;
          end else if (tmo_hit) begin
            // abandon the op; shutdown level follows the host so IDLE can retry it
            err_timeout   <= 1'b1;
            sns_update    <= 1'b0;
            sns_tempWrite <= NO_T;
            sns_shutdown  <= host_shutdown;
            op            <= OP_NONE;
            state         <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_SHDN: begin
          tmo_cnt <= '0;
          if (!host_shutdown) begin
            sns_shutdown <= 1'b0;
            op           <= OP_SHDN_EXIT;
            state        <= ST_WAIT_BUSY;
          end
        end
        default: begin
          op    <= OP_NONE;
          state <= ST_IDLE;
        end
      endcase

      // placed after the issue clear so a same-kind request arriving now survives
      if (bnd_req_valid && (bnd_req_kind != NO_T)) begin
        slot_vld[bnd_req_kind] <= 1'b1;
        slot_val[bnd_req_kind] <= bnd_req_val;
      end
    end
  end

endmodule
